ahbl_master_arbiter: RTL and testbench

Two-master AHB-Lite arbiter sharing the single system bus between the FRV CPU (M0) and a second bus master (M1, e.g. an I2S-capture DMA) ahead of ahbl_splitter. Each master port has a registered input stage. Every accepted master address phase is buffered, arbitrated, then replayed onto the shared bus as a single NONSEQ transfer. Losing masters are stalled through their own HREADY.

---
 rtl/ahbl_master_arbiter.sv | 137 +++++++++++++
 tb/tb_ahbl_master_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_master_arbiter.sv
// ahbl_master_arbiter: two-master AHB-Lite arbiter. Each master's address phase
// is buffered and replayed onto the shared bus as a single NONSEQ transfer.
module ahbl_master_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    output logic [1:0]  GNT
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DATA} state_t;

    state_t      r_st0, r_st1, w_nst0, w_nst1;
    logic [31:0] r_addr0, r_addr1, r_haddr;
    logic [2:0]  r_size0, r_size1, r_hsize;
    logic        r_wr0, r_wr1, r_hwrite;
    logic [1:0]  r_htrans;
    logic        r_last;
    logic        w_cap0, w_cap1, w_req0, w_req1, w_win0, w_win1;
    logic        w_unused;

    assign w_unused = ^{M0_HTRANS[0], M1_HTRANS[0]};

    function automatic state_t f_next(state_t st, logic cap, logic win, logic rdy);
        if (cap)
            return ST_WAIT;
        if (st == ST_WAIT && win)
            return ST_DATA;
        if (st == ST_DATA && rdy)
            return ST_IDLE;
        return st;
    endfunction

    assign M0_HREADY = (r_st0 == ST_IDLE) | ((r_st0 == ST_DATA) & HREADY);
    assign M1_HREADY = (r_st1 == ST_IDLE) | ((r_st1 == ST_DATA) & HREADY);
    assign w_cap0    = M0_HREADY & M0_HTRANS[1];
    assign w_cap1    = M1_HREADY & M1_HTRANS[1];

    // r_last=1 means M1 was granted last, so M0 wins the first tie after reset
    assign w_req0 = HREADY & (r_st0 == ST_WAIT);
    assign w_req1 = HREADY & (r_st1 == ST_WAIT);
    assign w_win1 = w_req1 & (~w_req0 | (ROUND_ROBIN & ~r_last));
    assign w_win0 = w_req0 & ~w_win1;

    always_comb begin
        w_nst0 = f_next(r_st0, w_cap0, w_win0, HREADY);
        w_nst1 = f_next(r_st1, w_cap1, w_win1, HREADY);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_st0 <= ST_IDLE;
            r_st1 <= ST_IDLE;
        end else begin
            r_st0 <= w_nst0;
            r_st1 <= w_nst1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr0 <= '0;
            r_size0 <= '0;
            r_wr0   <= 1'b0;
            r_addr1 <= '0;
            r_size1 <= '0;
            r_wr1   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (w_cap0) begin
                r_addr0 <= M0_HADDR;
                r_size0 <= M0_HSIZE;
                r_wr0   <= M0_HWRITE;
            end
            if (w_cap1) begin
                r_addr1 <= M1_HADDR;
                r_size1 <= M1_HSIZE;
                r_wr1   <= M1_HWRITE;
            end
            if (w_win0 | w_win1)
                r_last <= w_win1;
        end
    end

    // While the slave stalls, the previously driven address phase is held
    always_comb begin
        HTRANS = r_htrans;
        HADDR  = r_haddr;
        HSIZE  = r_hsize;
        HWRITE = r_hwrite;
        if (HREADY) begin
            HTRANS = (w_win0 | w_win1) ? 2'b10 : 2'b00;
            HADDR  = w_win0 ? r_addr0 : w_win1 ? r_addr1 : r_haddr;
            HSIZE  = w_win0 ? r_size0 : w_win1 ? r_size1 : r_hsize;
            HWRITE = w_win0 ? r_wr0   : w_win1 ? r_wr1   : r_hwrite;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_htrans <= 2'b00;
            r_haddr  <= '0;
            r_hsize  <= '0;
            r_hwrite <= 1'b0;
        end else begin
            r_htrans <= HTRANS;
            r_haddr  <= HADDR;
            r_hsize  <= HSIZE;
            r_hwrite <= HWRITE;
        end
    end

    assign GNT       = {r_st1 == ST_DATA, r_st0 == ST_DATA};
    assign HWDATA    = GNT[0] ? M0_HWDATA : GNT[1] ? M1_HWDATA : 32'h0;
    assign M0_HRDATA = HRDATA;
    assign M1_HRDATA = HRDATA;
endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// tb_ahbl_master_arbiter: directed bench for the two-master arbiter; a
// round-robin and a fixed-priority instance share every input.
module tb_ahbl_master_arbiter;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, HRDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic        M0_HWRITE, M1_HWRITE, HREADY;

    logic        rr_m0_hready, rr_m1_hready, rr_hwrite, fp_m0_hready, fp_m1_hready, fp_hwrite;
    logic [31:0] rr_m0_hrdata, rr_m1_hrdata, rr_haddr, rr_hwdata;
    logic [31:0] fp_m0_hrdata, fp_m1_hrdata, fp_haddr, fp_hwdata;
    logic [1:0]  rr_htrans, rr_gnt, fp_htrans, fp_gnt;
    logic [2:0]  rr_hsize, fp_hsize;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(rr_m0_hready), .M0_HRDATA(rr_m0_hrdata),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(rr_m1_hready), .M1_HRDATA(rr_m1_hrdata),
        .HADDR(rr_haddr), .HTRANS(rr_htrans), .HSIZE(rr_hsize), .HWRITE(rr_hwrite),
        .HWDATA(rr_hwdata), .HREADY(HREADY), .HRDATA(HRDATA), .GNT(rr_gnt)
    );

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b0)) u_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(fp_m0_hready), .M0_HRDATA(fp_m0_hrdata),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(fp_m1_hready), .M1_HRDATA(fp_m1_hrdata),
        .HADDR(fp_haddr), .HTRANS(fp_htrans), .HSIZE(fp_hsize), .HWRITE(fp_hwrite),
        .HWDATA(fp_hwdata), .HREADY(HREADY), .HRDATA(HRDATA), .GNT(fp_gnt)
    );

    // Each cycle starts 1 time unit after the rising edge; checks run at +4
    task automatic nxt;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_masters;
        M0_HADDR = '0; M0_HTRANS = 2'b00; M0_HSIZE = 3'd0; M0_HWRITE = 1'b0; M0_HWDATA = '0;
        M1_HADDR = '0; M1_HTRANS = 2'b00; M1_HSIZE = 3'd0; M1_HWRITE = 1'b0; M1_HWDATA = '0;
    endtask

    task automatic do_reset;
        HRESETn = 1'b0;
        idle_masters();
        HREADY = 1'b1;
        HRDATA = '0;
        nxt();
        nxt();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset;
        HRESETn = 1'b0;
        idle_masters();
        HREADY = 1'b1;
        HRDATA = '0;
        nxt();
        #3;
        n_cmp++; if (rr_htrans !== 2'b00) begin n_bad++; $display("FAIL reset_htrans: got %b want 00", rr_htrans); end
        n_cmp++; if (rr_haddr !== 32'h0) begin n_bad++; $display("FAIL reset_haddr: got %h want 0", rr_haddr); end
        n_cmp++; if (rr_hsize !== 3'd0) begin n_bad++; $display("FAIL reset_hsize: got %h want 0", rr_hsize); end
        n_cmp++; if (rr_hwrite !== 1'b0) begin n_bad++; $display("FAIL reset_hwrite: got %b want 0", rr_hwrite); end
        n_cmp++; if (rr_hwdata !== 32'h0) begin n_bad++; $display("FAIL reset_hwdata: got %h want 0", rr_hwdata); end
        n_cmp++; if (rr_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", rr_gnt); end
        n_cmp++; if (rr_m0_hready !== 1'b1) begin n_bad++; $display("FAIL reset_m0_hready: got %b want 1", rr_m0_hready); end
        n_cmp++; if (rr_m1_hready !== 1'b1) begin n_bad++; $display("FAIL reset_m1_hready: got %b want 1", rr_m1_hready); end
        n_cmp++; if (fp_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_fp_gnt: got %b want 00", fp_gnt); end
        nxt();
        HRESETn = 1'b1;
    endtask

    task automatic test_single_read;
        M0_HADDR = 32'h10; M0_HTRANS = 2'b10; M0_HSIZE = 3'd2;
        #3;
        n_cmp++; if (rr_m0_hready !== 1'b1) begin n_bad++; $display("FAIL rd_c0_hready: got %b want 1", rr_m0_hready); end
        nxt();
        M0_HADDR = '0; M0_HTRANS = 2'b00;
        #3;
        n_cmp++; if (rr_htrans !== 2'b10) begin n_bad++; $display("FAIL rd_c1_htrans: got %b want 10", rr_htrans); end
        n_cmp++; if (rr_haddr !== 32'h10) begin n_bad++; $display("FAIL rd_c1_haddr: got %h want 10", rr_haddr); end
        n_cmp++; if (rr_hsize !== 3'd2) begin n_bad++; $display("FAIL rd_c1_hsize: got %h want 2", rr_hsize); end
        n_cmp++; if (rr_m0_hready !== 1'b0) begin n_bad++; $display("FAIL rd_c1_hready: got %b want 0", rr_m0_hready); end
        n_cmp++; if (rr_gnt !== 2'b00) begin n_bad++; $display("FAIL rd_c1_gnt: got %b want 00", rr_gnt); end
        nxt();
        HRDATA = 32'hDEADBEEF;
        #3;
        n_cmp++; if (rr_gnt !== 2'b01) begin n_bad++; $display("FAIL rd_c2_gnt: got %b want 01", rr_gnt); end
        n_cmp++; if (rr_m0_hready !== 1'b1) begin n_bad++; $display("FAIL rd_c2_hready: got %b want 1", rr_m0_hready); end
        n_cmp++; if (rr_m0_hrdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_c2_m0_hrdata: got %h want deadbeef", rr_m0_hrdata); end
        n_cmp++; if (rr_m1_hrdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_c2_m1_hrdata: got %h want deadbeef", rr_m1_hrdata); end
        n_cmp++; if (rr_htrans !== 2'b00) begin n_bad++; $display("FAIL rd_c2_htrans: got %b want 00", rr_htrans); end
        nxt();
        HRDATA = '0;
        #3;
        n_cmp++; if (rr_gnt !== 2'b00) begin n_bad++; $display("FAIL rd_c3_gnt: got %b want 00", rr_gnt); end
        nxt();
    endtask

    task automatic test_back_to_back;
        logic [1:0]  e_tr [0:10];
        logic [31:0] e_ad [0:10];
        logic [1:0]  e_gn [0:10];
        int i0, i1, s0, s1;
        logic a0, a1;
        e_tr = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
        e_ad = '{32'h0, 32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208, 32'h10C, 32'h20C, 32'h0, 32'h0};
        e_gn = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        i0 = 0; i1 = 0; s0 = 0; s1 = 0;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            M0_HTRANS = (i0 < 4) ? 2'b10 : 2'b00;
            M0_HADDR  = 32'h100 + 32'(4 * i0);
            M1_HTRANS = (i1 < 4) ? 2'b10 : 2'b00;
            M1_HADDR  = 32'h200 + 32'(4 * i1);
            #3;
            n_cmp++; if (rr_htrans !== e_tr[c]) begin n_bad++; $display("FAIL b2b_rr_htrans c%0d: got %b want %b", c, rr_htrans, e_tr[c]); end
            n_cmp++; if (fp_htrans !== e_tr[c]) begin n_bad++; $display("FAIL b2b_fp_htrans c%0d: got %b want %b", c, fp_htrans, e_tr[c]); end
            if (e_tr[c] == 2'b10) begin
                n_cmp++; if (rr_haddr !== e_ad[c]) begin n_bad++; $display("FAIL b2b_rr_haddr c%0d: got %h want %h", c, rr_haddr, e_ad[c]); end
                n_cmp++; if (fp_haddr !== e_ad[c]) begin n_bad++; $display("FAIL b2b_fp_haddr c%0d: got %h want %h", c, fp_haddr, e_ad[c]); end
            end
            n_cmp++; if (rr_gnt !== e_gn[c]) begin n_bad++; $display("FAIL b2b_rr_gnt c%0d: got %b want %b", c, rr_gnt, e_gn[c]); end
            n_cmp++; if (fp_gnt !== e_gn[c]) begin n_bad++; $display("FAIL b2b_fp_gnt c%0d: got %b want %b", c, fp_gnt, e_gn[c]); end
            a0 = rr_m0_hready && (i0 < 4);
            a1 = rr_m1_hready && (i1 < 4);
            if (!rr_m0_hready && i0 < 4) s0++;
            if (!rr_m1_hready && i1 < 4) s1++;
            nxt();
            if (a0) i0++;
            if (a1) i1++;
        end
        idle_masters();
        n_cmp++; if (i0 !== 4 || i1 !== 4) begin n_bad++; $display("FAIL b2b_done: got %0d/%0d want 4/4", i0, i1); end
        n_cmp++; if (s0 !== 3) begin n_bad++; $display("FAIL b2b_m0_stalls: got %0d want 3", s0); end
        n_cmp++; if (s1 !== 4) begin n_bad++; $display("FAIL b2b_m1_stalls: got %0d want 4", s1); end
    endtask

    task automatic test_priority;
        do_reset();
        M0_HADDR = 32'h300; M0_HTRANS = 2'b10;
        nxt();
        M0_HTRANS = 2'b00;
        #3;
        n_cmp++; if (rr_haddr !== 32'h300 || rr_htrans !== 2'b10) begin n_bad++; $display("FAIL pri_c1: got %h/%b want 300/10", rr_haddr, rr_htrans); end
        nxt();
        #3;
        n_cmp++; if (rr_gnt !== 2'b01) begin n_bad++; $display("FAIL pri_c2_gnt: got %b want 01", rr_gnt); end
        nxt();
        M0_HADDR = 32'h304; M0_HTRANS = 2'b10; M1_HADDR = 32'h400; M1_HTRANS = 2'b10;
        #3;
        n_cmp++; if (rr_m0_hready !== 1'b1 || rr_m1_hready !== 1'b1) begin n_bad++; $display("FAIL pri_c3_hready: got %b%b want 11", rr_m0_hready, rr_m1_hready); end
        nxt();
        idle_masters();
        #3;
        n_cmp++; if (rr_haddr !== 32'h400 || rr_htrans !== 2'b10) begin n_bad++; $display("FAIL pri_c4_rr: got %h/%b want 400/10", rr_haddr, rr_htrans); end
        n_cmp++; if (fp_haddr !== 32'h304 || fp_htrans !== 2'b10) begin n_bad++; $display("FAIL pri_c4_fp: got %h/%b want 304/10", fp_haddr, fp_htrans); end
        nxt();
        #3;
        n_cmp++; if (rr_gnt !== 2'b10 || rr_haddr !== 32'h304) begin n_bad++; $display("FAIL pri_c5_rr: got %b/%h want 10/304", rr_gnt, rr_haddr); end
        n_cmp++; if (fp_gnt !== 2'b01 || fp_haddr !== 32'h400) begin n_bad++; $display("FAIL pri_c5_fp: got %b/%h want 01/400", fp_gnt, fp_haddr); end
        nxt();
        #3;
        n_cmp++; if (rr_gnt !== 2'b01) begin n_bad++; $display("FAIL pri_c6_rr_gnt: got %b want 01", rr_gnt); end
        n_cmp++; if (fp_gnt !== 2'b10) begin n_bad++; $display("FAIL pri_c6_fp_gnt: got %b want 10", fp_gnt); end
        nxt();
    endtask

    task automatic test_wait_states;
        do_reset();
        M0_HWDATA = 32'hAA;
        M1_HADDR = 32'h5000_0000; M1_HTRANS = 2'b10; M1_HWRITE = 1'b1; M1_HSIZE = 3'd2;
        nxt();
        M1_HTRANS = 2'b00; M1_HWDATA = 32'h41;
        #3;
        n_cmp++; if (rr_htrans !== 2'b10 || rr_haddr !== 32'h5000_0000) begin n_bad++; $display("FAIL ws_c1_addr: got %b/%h want 10/50000000", rr_htrans, rr_haddr); end
        n_cmp++; if (rr_hwrite !== 1'b1) begin n_bad++; $display("FAIL ws_c1_hwrite: got %b want 1", rr_hwrite); end
        n_cmp++; if (rr_m1_hready !== 1'b0) begin n_bad++; $display("FAIL ws_c1_m1_hready: got %b want 0", rr_m1_hready); end
        nxt();
        HREADY = 1'b0;
        M0_HADDR = 32'h20; M0_HTRANS = 2'b10;
        #3;
        n_cmp++; if (rr_m0_hready !== 1'b1) begin n_bad++; $display("FAIL ws_c2_m0_hready: got %b want 1", rr_m0_hready); end
        for (int c = 2; c < 5; c++) begin
            if (c > 2) begin
                nxt();
                M0_HTRANS = 2'b00;
                #3;
                n_cmp++; if (rr_m0_hready !== 1'b0) begin n_bad++; $display("FAIL ws_c%0d_m0_hready: got %b want 0", c, rr_m0_hready); end
            end
            n_cmp++; if (rr_htrans !== 2'b10 || rr_haddr !== 32'h5000_0000) begin n_bad++; $display("FAIL ws_c%0d_hold: got %b/%h want 10/50000000", c, rr_htrans, rr_haddr); end
            n_cmp++; if (rr_hwdata !== 32'h41) begin n_bad++; $display("FAIL ws_c%0d_hwdata: got %h want 41", c, rr_hwdata); end
            n_cmp++; if (rr_m1_hready !== 1'b0) begin n_bad++; $display("FAIL ws_c%0d_m1_hready: got %b want 0", c, rr_m1_hready); end
            n_cmp++; if (rr_gnt !== 2'b10) begin n_bad++; $display("FAIL ws_c%0d_gnt: got %b want 10", c, rr_gnt); end
        end
        nxt();
        HREADY = 1'b1;
        #3;
        n_cmp++; if (rr_m1_hready !== 1'b1) begin n_bad++; $display("FAIL ws_c5_m1_hready: got %b want 1", rr_m1_hready); end
        n_cmp++; if (rr_hwdata !== 32'h41) begin n_bad++; $display("FAIL ws_c5_hwdata: got %h want 41", rr_hwdata); end
        n_cmp++; if (rr_htrans !== 2'b10 || rr_haddr !== 32'h20 || rr_hwrite !== 1'b0) begin n_bad++; $display("FAIL ws_c5_m0_addr: got %b/%h/%b want 10/20/0", rr_htrans, rr_haddr, rr_hwrite); end
        nxt();
        M1_HWDATA = '0;
        #3;
        n_cmp++; if (rr_gnt !== 2'b01 || rr_m0_hready !== 1'b1) begin n_bad++; $display("FAIL ws_c6_m0: got %b/%b want 01/1", rr_gnt, rr_m0_hready); end
        n_cmp++; if (rr_hwdata !== 32'hAA) begin n_bad++; $display("FAIL ws_c6_hwdata: got %h want aa", rr_hwdata); end
        nxt();
        idle_masters();
    endtask

    task automatic test_overlap;
        do_reset();
        M0_HADDR = 32'h40; M0_HTRANS = 2'b10;
        nxt();
        M0_HTRANS = 2'b00; M1_HADDR = 32'h600; M1_HTRANS = 2'b10;
        #3;
        n_cmp++; if (rr_haddr !== 32'h40 || rr_m1_hready !== 1'b1) begin n_bad++; $display("FAIL ov_c1: got %h/%b want 40/1", rr_haddr, rr_m1_hready); end
        nxt();
        M1_HTRANS = 2'b00;
        #3;
        n_cmp++; if (rr_gnt !== 2'b01) begin n_bad++; $display("FAIL ov_c2_gnt: got %b want 01", rr_gnt); end
        n_cmp++; if (rr_htrans !== 2'b10 || rr_haddr !== 32'h600) begin n_bad++; $display("FAIL ov_c2_addr: got %b/%h want 10/600", rr_htrans, rr_haddr); end
        nxt();
        #3;
        n_cmp++; if (rr_gnt !== 2'b10 || rr_htrans !== 2'b00) begin n_bad++; $display("FAIL ov_c3: got %b/%b want 10/00", rr_gnt, rr_htrans); end
        nxt();
    endtask

    task automatic test_reset_mid;
        M1_HADDR = 32'h700; M1_HTRANS = 2'b10;
        nxt();
        M1_HTRANS = 2'b00; M0_HADDR = 32'h44; M0_HTRANS = 2'b10;
        #3;
        n_cmp++; if (rr_haddr !== 32'h700) begin n_bad++; $display("FAIL rm_c1_haddr: got %h want 700", rr_haddr); end
        nxt();
        M0_HTRANS = 2'b00; M1_HWDATA = 32'h77;
        #3;
        n_cmp++; if (rr_gnt !== 2'b10 || rr_haddr !== 32'h44) begin n_bad++; $display("FAIL rm_c2_pre: got %b/%h want 10/44", rr_gnt, rr_haddr); end
        HRESETn = 1'b0;
        #1;
        n_cmp++; if (rr_htrans !== 2'b00 || rr_gnt !== 2'b00) begin n_bad++; $display("FAIL rm_async: got %b/%b want 00/00", rr_htrans, rr_gnt); end
        n_cmp++; if (rr_m0_hready !== 1'b1 || rr_m1_hready !== 1'b1) begin n_bad++; $display("FAIL rm_hready: got %b%b want 11", rr_m0_hready, rr_m1_hready); end
        n_cmp++; if (rr_hwdata !== 32'h0) begin n_bad++; $display("FAIL rm_hwdata: got %h want 0", rr_hwdata); end
        nxt();
        HRESETn = 1'b1;
        M1_HWDATA = '0;
        for (int c = 0; c < 4; c++) begin
            #3;
            n_cmp++; if (rr_htrans !== 2'b00 || rr_gnt !== 2'b00) begin n_bad++; $display("FAIL rm_post c%0d: got %b/%b want 00/00", c, rr_htrans, rr_gnt); end
            nxt();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_priority();
        test_wait_states();
        test_overlap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
